// File: rtl/bootstrap_loader.sv
// Power-up loader: copies a SPI flash image (READ 0x03) into external SRAM,
// then hands the SRAM bus to the system and holds boot_done until reset.
module bootstrap_loader #(
    parameter logic [23:0] FLASH_START = 24'h000000,
    parameter int unsigned BOOT_BYTES  = 65536,
    parameter logic [21:0] RAM_START   = 22'h000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        phi,
    input  logic        boot_enable,
    output logic        boot_done,
    output logic        flash_cs,
    output logic        flash_ck,
    output logic        flash_si,
    input  logic        flash_so,
    input  logic [1:0]  cs,
    input  logic        rw_in,
    input  logic [15:0] addr_in,
    input  logic [7:0]  data_in,
    output logic        cs0,
    output logic        cs1,
    output logic        rw_out,
    output logic [15:0] addr_out,
    output logic [5:0]  addr_ext,
    output logic [7:0]  data_out
);

    typedef enum logic [2:0] {IDLE, CMD, READ, WAITPHI, WRITE, DONE} state_t;

    localparam logic [31:0] CMD_WORD = {8'h03, FLASH_START};
    localparam logic [22:0] N_INIT   = 23'(BOOT_BYTES);

    state_t      state_q, state_d;
    logic        phi_s1_q, phi_s2_q, phi_s3_q;
    logic [31:0] shift_q, shift_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic [21:0] dst_q, dst_d;
    logic [22:0] left_q, left_d;
    logic        flash_cs_q, flash_cs_d;
    logic        flash_ck_q, flash_ck_d;
    logic        flash_si_q, flash_si_d;
    logic        cs0_q, cs0_d, cs1_q, cs1_d;
    logic        rw_q, rw_d;
    logic [15:0] addr_q, addr_d;
    logic [5:0]  ext_q, ext_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;

    logic phi_rise, phi_fall, cmd_last, read_last, last_byte;

    assign phi_rise  = phi_s2_q & ~phi_s3_q;
    assign phi_fall  = ~phi_s2_q & phi_s3_q;
    // The falling ck edge after the final rise closes each shifting phase.
    assign cmd_last  = (state_q == CMD)  && flash_ck_q && (bit_cnt_q == 6'd32);
    assign read_last = (state_q == READ) && flash_ck_q && (bit_cnt_q == 6'd8);
    assign last_byte = (left_q == 23'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            phi_s1_q   <= 1'b0;
            phi_s2_q   <= 1'b0;
            phi_s3_q   <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            byte_q     <= '0;
            dst_q      <= '0;
            left_q     <= '0;
            flash_cs_q <= 1'b1;
            flash_ck_q <= 1'b0;
            flash_si_q <= 1'b0;
            cs0_q      <= 1'b1;
            cs1_q      <= 1'b1;
            rw_q       <= 1'b1;
            addr_q     <= '0;
            ext_q      <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phi_s1_q   <= phi;
            phi_s2_q   <= phi_s1_q;
            phi_s3_q   <= phi_s2_q;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_q     <= byte_d;
            dst_q      <= dst_d;
            left_q     <= left_d;
            flash_cs_q <= flash_cs_d;
            flash_ck_q <= flash_ck_d;
            flash_si_q <= flash_si_d;
            cs0_q      <= cs0_d;
            cs1_q      <= cs1_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            ext_q      <= ext_d;
            data_q     <= data_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (boot_enable) state_d = CMD;
            CMD:     if (cmd_last) state_d = READ;
            READ:    if (read_last) state_d = WAITPHI;
            WAITPHI: if (phi_rise) state_d = WRITE;
            WRITE:   if (phi_fall) state_d = last_byte ? DONE : READ;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_d     = byte_q;
        dst_d      = dst_q;
        left_d     = left_q;
        flash_cs_d = flash_cs_q;
        flash_ck_d = flash_ck_q;
        flash_si_d = flash_si_q;
        cs0_d      = cs0_q;
        cs1_d      = cs1_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        ext_d      = ext_q;
        data_d     = data_q;
        done_d     = done_q;
        case (state_q)
            IDLE: begin
                flash_cs_d = 1'b1;
                flash_ck_d = 1'b0;
                cs0_d      = 1'b1;
                cs1_d      = 1'b1;
                rw_d       = 1'b1;
                if (boot_enable) begin
                    shift_d    = CMD_WORD;
                    flash_si_d = CMD_WORD[31];
                    flash_cs_d = 1'b0;
                    bit_cnt_d  = '0;
                    dst_d      = RAM_START;
                    left_d     = N_INIT;
                end
            end
            CMD: begin
                if (!flash_ck_q) begin
                    flash_ck_d = 1'b1;
                    bit_cnt_d  = bit_cnt_q + 6'd1;
                end else begin
                    flash_ck_d = 1'b0;
                    if (cmd_last) begin
                        bit_cnt_d  = '0;
                        flash_si_d = 1'b0;
                    end else begin
                        shift_d    = shift_q << 1;
                        flash_si_d = shift_q[30];
                    end
                end
            end
            READ: begin
                rw_d = 1'b1;
                if (!flash_ck_q) begin
                    flash_ck_d = 1'b1;
                    byte_d     = {byte_q[6:0], flash_so};
                    bit_cnt_d  = bit_cnt_q + 6'd1;
                end else begin
                    flash_ck_d = 1'b0;
                    if (read_last) bit_cnt_d = '0;
                end
            end
            WAITPHI: begin
                if (phi_rise) begin
                    cs0_d  = dst_q[21];
                    cs1_d  = ~dst_q[21];
                    rw_d   = 1'b0;
                    addr_d = dst_q[15:0];
                    ext_d  = dst_q[21:16];
                    data_d = byte_q;
                end
            end
            WRITE: begin
                // rw_out stays low this clk and releases in the following state.
                if (phi_fall) begin
                    cs0_d  = 1'b1;
                    cs1_d  = 1'b1;
                    dst_d  = dst_q + 22'd1;
                    left_d = left_q - 23'd1;
                    if (last_byte) flash_cs_d = 1'b1;
                end
            end
            DONE: begin
                flash_cs_d = 1'b1;
                flash_ck_d = 1'b0;
                done_d     = 1'b1;
                cs0_d      = cs[0];
                cs1_d      = cs[1];
                rw_d       = rw_in;
                addr_d     = addr_in;
                ext_d      = '0;
                data_d     = data_in;
            end
            default: ;
        endcase
    end

    assign boot_done = done_q;
    assign flash_cs  = flash_cs_q;
    assign flash_ck  = flash_ck_q;
    assign flash_si  = flash_si_q;
    assign cs0       = cs0_q;
    assign cs1       = cs1_q;
    assign rw_out    = rw_q;
    assign addr_out  = addr_q;
    assign addr_ext  = ext_q;
    assign data_out  = data_q;

endmodule

// File: tb/tb_bootstrap_loader.sv
// Directed bench for bootstrap_loader: SPI flash model, SRAM write monitor,
// pass-through and mid-load reset scenarios.
module tb_bootstrap_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        phi = 1'b0;
    logic        boot_enable = 1'b0;
    logic        flash_so = 1'b0;
    logic        boot_done, flash_cs, flash_ck, flash_si, cs0, cs1, rw_out;
    logic [1:0]  cs = 2'b11;
    logic        rw_in = 1'b1;
    logic [15:0] addr_in = 16'h0000;
    logic [7:0]  data_in = 8'h00;
    logic [15:0] addr_out;
    logic [5:0]  addr_ext;
    logic [7:0]  data_out;

    int n_checks = 0;
    int n_errors = 0;

    bootstrap_loader #(.BOOT_BYTES(4)) dut (
        .clk(clk), .reset(reset), .phi(phi), .boot_enable(boot_enable),
        .boot_done(boot_done), .flash_cs(flash_cs), .flash_ck(flash_ck),
        .flash_si(flash_si), .flash_so(flash_so), .cs(cs), .rw_in(rw_in),
        .addr_in(addr_in), .data_in(data_in), .cs0(cs0), .cs1(cs1),
        .rw_out(rw_out), .addr_out(addr_out), .addr_ext(addr_ext),
        .data_out(data_out)
    );

    always #5 clk = ~clk;
    always #80 phi = ~phi;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // SPI mode-0 flash: captures si on ck rise, presents so on ck fall.
    logic [7:0]  flash_mem [0:7];
    logic [7:0]  cur_byte;
    logic        prev_ck = 1'b0;
    int          rise_cnt = 0, out_bit = 0, cmd_cnt = 0;
    logic [31:0] cmd_word = 32'h0, cmd_cap = 32'h0;

    always @(negedge clk) begin
        if (flash_cs) begin
            rise_cnt = 0;
            out_bit  = 0;
        end else if (flash_ck && !prev_ck) begin
            if (rise_cnt < 32) cmd_word = {cmd_word[30:0], flash_si};
            rise_cnt++;
            if (rise_cnt == 32) begin
                cmd_cap = cmd_word;
                cmd_cnt++;
            end
        end else if (!flash_ck && prev_ck && rise_cnt >= 32) begin
            cur_byte = flash_mem[(out_bit / 8) % 8];
            flash_so = cur_byte[7 - (out_bit % 8)];
            out_bit++;
        end
        prev_ck = flash_ck;
    end

    // SRAM write monitor.
    int          wr_cnt = 0, wr_end = 0, width = 0, cs_rise_cnt = 0, flash_low_cnt = 0;
    logic        strobe_prev = 1'b0, fcs_prev = 1'b1, mon_en = 1'b1;
    logic        strobe;
    logic [15:0] wr_addr [0:15];
    logic [5:0]  wr_ext [0:15];
    logic [7:0]  wr_data [0:15];
    logic [1:0]  wr_bank [0:15];
    logic        wr_rw [0:15];
    int          wr_width [0:15];

    always @(negedge clk) begin
        strobe = mon_en && (!cs0 || !cs1);
        if (strobe && !strobe_prev && wr_cnt < 16) begin
            wr_addr[wr_cnt] = addr_out;
            wr_ext[wr_cnt]  = addr_ext;
            wr_data[wr_cnt] = data_out;
            wr_bank[wr_cnt] = {cs1, cs0};
            wr_rw[wr_cnt]   = rw_out;
            wr_cnt++;
            width = 0;
        end
        if (strobe) width++;
        if (!strobe && strobe_prev) begin
            if (wr_cnt > 0) wr_width[wr_cnt - 1] = width;
            wr_end++;
        end
        strobe_prev = strobe;
        if (flash_cs && !fcs_prev) cs_rise_cnt++;
        if (!flash_cs) flash_low_cnt++;
        fcs_prev = flash_cs;
    end

    logic [7:0] exp_data [0:3];
    int base_a, base_b, base_c;

    initial begin
        flash_mem[0] = 8'hA5; flash_mem[1] = 8'h3C; flash_mem[2] = 8'h96; flash_mem[3] = 8'h0F;
        flash_mem[4] = 8'hFF; flash_mem[5] = 8'hFF; flash_mem[6] = 8'hFF; flash_mem[7] = 8'hFF;
        exp_data[0] = 8'hA5; exp_data[1] = 8'h3C; exp_data[2] = 8'h96; exp_data[3] = 8'h0F;

        repeat (3) @(negedge clk);
        check_value("rst_spi",  {29'h0, flash_cs, flash_ck, flash_si}, 32'h4);
        check_value("rst_bus",  {29'h0, cs1, cs0, rw_out}, 32'h7);
        check_value("rst_addr", {10'h0, addr_ext, addr_out}, 32'h0);
        check_value("rst_data", {23'h0, boot_done, data_out}, 32'h0);

        reset = 1'b1;
        base_a = flash_low_cnt;
        repeat (200) @(negedge clk);
        check_value("idle_flash_cs", flash_cs, 1);
        check_value("idle_no_select", flash_low_cnt - base_a, 0);

        base_a = cs_rise_cnt;
        base_b = cmd_cnt;
        boot_enable = 1'b1;
        for (int i = 0; i < 5000 && !boot_done; i++) @(negedge clk);
        check_value("load_done", boot_done, 1);
        check_value("cmd_count", cmd_cnt - base_b, 1);
        check_value("cmd_word", cmd_cap, 32'h03000000);
        check_value("cs_low_throughout", cs_rise_cnt - base_a, 1);
        check_value("write_count", wr_cnt, 4);
        for (int i = 0; i < 4; i++) begin
            check_value($sformatf("wr%0d_addr", i), {10'h0, wr_ext[i], wr_addr[i]}, i);
            check_value($sformatf("wr%0d_data", i), wr_data[i], exp_data[i]);
            check_value($sformatf("wr%0d_bank_rw", i), {wr_bank[i], wr_rw[i]}, 3'b100);
            check_value($sformatf("wr%0d_width", i), wr_width[i], 8);
        end
        check_value("done_flash_cs", flash_cs, 1);

        boot_enable = 1'b0;
        repeat (5) @(negedge clk);
        boot_enable = 1'b1;
        base_a = flash_low_cnt;
        repeat (60) @(negedge clk);
        check_value("toggle_done", boot_done, 1);
        check_value("toggle_no_flash", flash_low_cnt - base_a, 0);
        check_value("toggle_no_write", wr_cnt, 4);

        mon_en = 1'b0;
        cs = 2'b01; rw_in = 1'b0; addr_in = 16'h1234; data_in = 8'h5A;
        @(negedge clk);
        check_value("pass_cs_rw", {29'h0, cs1, cs0, rw_out}, 32'h2);
        check_value("pass_addr", {10'h0, addr_ext, addr_out}, 32'h1234);
        check_value("pass_data", data_out, 8'h5A);

        cs = 2'b11; rw_in = 1'b1;
        boot_enable = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        mon_en = 1'b1;
        check_value("reset_clears_done", boot_done, 0);

        base_a = wr_end;
        boot_enable = 1'b1;
        for (int i = 0; i < 3000 && wr_end == base_a; i++) @(negedge clk);
        check_value("abort_first_write", wr_end - base_a, 1);
        repeat (3) @(negedge clk);
        boot_enable = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_value("abort_spi", {29'h0, flash_cs, flash_ck, flash_si}, 32'h4);
        check_value("abort_bus", {29'h0, cs1, cs0, rw_out}, 32'h7);
        check_value("abort_data", {23'h0, boot_done, data_out}, 32'h0);

        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        base_b = cmd_cnt;
        base_c = wr_cnt;
        boot_enable = 1'b1;
        for (int i = 0; i < 3000 && wr_cnt == base_c; i++) @(negedge clk);
        check_value("restart_cmd_count", cmd_cnt - base_b, 1);
        check_value("restart_cmd_word", cmd_cap, 32'h03000000);
        check_value("restart_write", wr_cnt - base_c, 1);
        check_value("restart_addr", {10'h0, wr_ext[base_c], wr_addr[base_c]}, 32'h0);
        check_value("restart_data", wr_data[base_c], 8'hA5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
